// File: rtl/stage_if_prefetch_pkg.sv
// Shared types and constants for the instruction-fetch prefetch stage.
package stage_if_prefetch_pkg;

  localparam logic [3:0]  CAUSE_INST_MISALIGNED   = 4'd0;
  localparam logic [3:0]  CAUSE_INST_ACCESS_FAULT = 4'd1;
  localparam logic [31:0] INST_NOP                = 32'h0000_0013;

  typedef enum logic {RUN, HALT} fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        trap_valid;
    logic [3:0]  cause;
    logic [31:0] tval;
  } fetch_entry_t;

  function automatic logic pc_aligned(input logic [31:0] pc, input int ialign);
    return (ialign == 16) ? !pc[0] : (pc[1:0] == 2'b00);
  endfunction

  function automatic fetch_entry_t trap_entry(input logic [31:0] pc, input logic [3:0] cause);
    fetch_entry_t e;
    e.pc         = pc;
    e.inst       = INST_NOP;
    e.trap_valid = 1'b1;
    e.cause      = cause;
    e.tval       = pc;
    return e;
  endfunction

endpackage

// File: rtl/stage_if_prefetch_if.sv
// Fetch-stage bus: redirect input, instruction-memory handshake and decode-side output.
interface stage_if_prefetch_if;

  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_fault;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pcplus4;
  logic [31:0] out_inst;
  logic        out_trap_valid;
  logic [3:0]  out_trap_cause;
  logic [31:0] out_trap_tval;

  modport master (
    input  redirect_valid, redirect_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_fault,
    input  out_ready,
    output imem_req_valid, imem_req_addr,
    output out_valid, out_pc, out_pcplus4, out_inst,
    output out_trap_valid, out_trap_cause, out_trap_tval
  );

  modport slave (
    output redirect_valid, redirect_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_fault,
    output out_ready,
    input  imem_req_valid, imem_req_addr,
    input  out_valid, out_pc, out_pcplus4, out_inst,
    input  out_trap_valid, out_trap_cause, out_trap_tval
  );

endinterface

// File: rtl/stage_if_prefetch_fifo.sv
// First-word-fall-through FIFO with synchronous flush; depth need not be a power of two.
module fetch_fifo #(
  parameter type T     = logic [31:0],
  parameter int  DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  T                             push_data,
  input  logic                         pop,
  output T                             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  T               mem [DEPTH];
  logic [PW-1:0]  rd_ptr, wr_ptr;
  logic           do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop && (count != '0);
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/stage_if_prefetch.sv
// Instruction-fetch stage: credit-limited prefetch into a FWFT entry FIFO, with
// redirect flushing, stale-response dropping and in-order trap delivery.
module stage_if_prefetch
  import stage_if_prefetch_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          IALIGN          = 32,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  stage_if_prefetch_if.master  bus
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int OW = $clog2(MAX_OUTSTANDING+1);

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic [OW-1:0] drop_cnt;
  logic [OW-1:0] outstanding;
  logic [CW-1:0] fifo_cnt;
  logic [31:0]   pcq_head;
  fetch_entry_t  enq_entry, head;

  logic          aligned, can_issue, req_fire, rsp_accept, mis_trap, enq, deq;
  logic [OW:0]   drop_total, drop_redirect;

  assign aligned = pc_aligned(fetch_pc, IALIGN);

  assign can_issue = (state == RUN) && !bus.redirect_valid && (drop_cnt == '0) && aligned
                  && (outstanding < OW'(MAX_OUTSTANDING))
                  && ((int'(fifo_cnt) + int'(outstanding)) < DEPTH);

  assign bus.imem_req_valid = !rst && can_issue;
  assign bus.imem_req_addr  = fetch_pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign rsp_accept = bus.imem_rsp_valid && !bus.redirect_valid
                   && (drop_cnt == '0) && (outstanding != '0);

  // The misaligned trap waits until every older response has been enqueued.
  assign mis_trap = !rst && (state == RUN) && !aligned && !bus.redirect_valid
                 && (outstanding == '0) && (fifo_cnt < CW'(DEPTH));

  assign enq = rsp_accept || mis_trap;
  assign deq = bus.out_valid && bus.out_ready;

  always_comb begin
    enq_entry = '0;
    if (mis_trap) begin
      enq_entry = trap_entry(fetch_pc, CAUSE_INST_MISALIGNED);
    end else if (bus.imem_rsp_fault) begin
      enq_entry = trap_entry(pcq_head, CAUSE_INST_ACCESS_FAULT);
    end else begin
      enq_entry.pc   = pcq_head;
      enq_entry.inst = bus.imem_rsp_data;
    end
  end

  // Responses still owed by memory at a redirect become drops; a same-cycle
  // response is one of them and is consumed immediately.
  assign drop_total    = {1'b0, drop_cnt} + {1'b0, outstanding};
  assign drop_redirect = (bus.imem_rsp_valid && (drop_total != '0))
                       ? drop_total - (OW+1)'(1) : drop_total;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else if (bus.redirect_valid) begin
      state    <= RUN;
      fetch_pc <= bus.redirect_pc;
      drop_cnt <= drop_redirect[OW-1:0];
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (bus.imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - OW'(1);
      if ((rsp_accept && bus.imem_rsp_fault) || mis_trap) state <= HALT;
    end
  end

  // Addresses of accepted requests; its occupancy is the outstanding count.
  fetch_fifo #(
    .T     (logic [31:0]),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect_valid),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (rsp_accept),
    .head      (pcq_head),
    .count     (outstanding)
  );

  fetch_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (DEPTH)
  ) u_entry_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect_valid),
    .push      (enq),
    .push_data (enq_entry),
    .pop       (deq),
    .head      (head),
    .count     (fifo_cnt)
  );

  assign bus.out_valid      = !rst && (fifo_cnt != '0);
  assign bus.out_pc         = head.pc;
  assign bus.out_pcplus4    = head.pc + 32'd4;
  assign bus.out_inst       = head.inst;
  assign bus.out_trap_valid = head.trap_valid;
  assign bus.out_trap_cause = head.cause;
  assign bus.out_trap_tval  = head.tval;

endmodule

// File: tb/tb_stage_if_prefetch.sv
// Randomised bench for stage_if_prefetch: bench-side memory plus an in-order
// stream model of what decode must see, checked every cycle.
module tb_stage_if_prefetch;
  import stage_if_prefetch_pkg::*;

  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stage_if_prefetch_if bus();

  stage_if_prefetch #(
    .DEPTH(DEPTH), .RESET_PC(RPC), .IALIGN(32), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic [31:0] addr;
    bit          killed;
    int          due;
  } mreq_t;

  mreq_t        mem_q[$];
  fetch_entry_t exp_q[$];
  logic [31:0]  m_pc;
  bit           m_halt;
  int           cyc;
  int           n_tests, n_fail;

  int           p_req_rdy, p_out_rdy, p_rsp, lat_min, lat_max, p_redir;
  bit           force_redir, redir_on_rsp;
  logic [31:0]  force_pc, fault_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0003;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- model + compare, at the falling edge ----------------
  int           live, drops, sz0;
  bit           exp_rv, rsp_live;
  mreq_t        r;
  fetch_entry_t e, hd;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_valid", bus.imem_req_valid, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      mem_q.delete();
      exp_q.delete();
      m_pc   = RPC;
      m_halt = 0;
    end else begin
      live = 0; drops = 0;
      foreach (mem_q[i]) if (mem_q[i].killed) drops++; else live++;
      exp_rv = !m_halt && !bus.redirect_valid && drops == 0 && m_pc[1:0] == 2'b00
            && live < MAXO && (exp_q.size() + live) < DEPTH;
      chk("req_valid", bus.imem_req_valid, exp_rv);
      if (exp_rv && bus.imem_req_valid) chk("req_addr", bus.imem_req_addr, m_pc);
      chk("out_valid", bus.out_valid, exp_q.size() != 0);
      if (bus.out_valid && exp_q.size() != 0) begin
        hd = exp_q[0];
        chk("out_pc", bus.out_pc, hd.pc);
        chk("out_pcplus4", bus.out_pcplus4, hd.pc + 32'd4);
        chk("out_inst", bus.out_inst, hd.inst);
        chk("out_trap_valid", bus.out_trap_valid, hd.trap_valid);
        if (hd.trap_valid) begin
          chk("out_trap_cause", bus.out_trap_cause, hd.cause);
          chk("out_trap_tval", bus.out_trap_tval, hd.tval);
        end
      end
      // advance the model across the coming rising edge
      sz0 = exp_q.size();
      rsp_live = 0;
      if (bus.imem_rsp_valid && mem_q.size() != 0) begin
        r = mem_q.pop_front();
        rsp_live = !r.killed;
      end
      if (bus.redirect_valid) begin
        exp_q.delete();
        foreach (mem_q[i]) mem_q[i].killed = 1;
        m_pc   = bus.redirect_pc;
        m_halt = 0;
      end else begin
        if (bus.out_valid && bus.out_ready && sz0 != 0) void'(exp_q.pop_front());
        if (rsp_live) begin
          if (bus.imem_rsp_fault) begin
            e = trap_entry(r.addr, CAUSE_INST_ACCESS_FAULT);
            m_halt = 1;
          end else begin
            e = '0;
            e.pc   = r.addr;
            e.inst = bus.imem_rsp_data;
          end
          exp_q.push_back(e);
        end else if (!m_halt && m_pc[1:0] != 2'b00 && live == 0 && sz0 < DEPTH) begin
          exp_q.push_back(trap_entry(m_pc, CAUSE_INST_MISALIGNED));
          m_halt = 1;
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          mem_q.push_back('{addr: bus.imem_req_addr, killed: 0,
                            due: cyc + int'($urandom_range(lat_max, lat_min))});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    cyc++;
  end

  // ---------------- stimulus, just after the rising edge ----------------
  task automatic drive();
    bus.out_ready      = ($urandom_range(99) < p_out_rdy);
    bus.imem_req_ready = ($urandom_range(99) < p_req_rdy);
    bus.imem_rsp_valid = 0;
    bus.imem_rsp_data  = '0;
    bus.imem_rsp_fault = 0;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc && $urandom_range(99) < p_rsp) begin
      bus.imem_rsp_valid = 1;
      bus.imem_rsp_data  = mem_word(mem_q[0].addr);
      bus.imem_rsp_fault = (mem_q[0].addr == fault_addr);
    end
    bus.redirect_valid = 0;
    if (force_redir) begin
      bus.redirect_valid = 1;
      bus.redirect_pc    = force_pc;
      force_redir        = 0;
    end else if (redir_on_rsp && bus.imem_rsp_valid) begin
      bus.redirect_valid = 1;
      bus.redirect_pc    = force_pc;
      redir_on_rsp       = 0;
    end else if ($urandom_range(999) < p_redir) begin
      bus.redirect_valid = 1;
      bus.redirect_pc    = {22'd0, 8'($urandom_range(255)), 2'b00}
                         + (($urandom_range(7) == 0) ? 32'd2 : 32'd0);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      drive();
    end
  endtask

  task automatic idle_inputs();
    bus.redirect_valid = 0; bus.redirect_pc = '0;
    bus.imem_req_ready = 0; bus.imem_rsp_valid = 0;
    bus.imem_rsp_data  = '0; bus.imem_rsp_fault = 0;
    bus.out_ready      = 0;
  endtask

  // Leaves the bench in the first cycle with rst low, inputs already driven.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; idle_inputs();
    repeat (2) @(posedge clk);
    #1; rst = 0;
    drive();
  endtask

  task automatic zero_wait();
    p_req_rdy = 100; p_out_rdy = 100; p_rsp = 100;
    lat_min = 1; lat_max = 1; p_redir = 0;
  endtask

  task automatic wait_out(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step(1);
      @(negedge clk);
      ok = bus.out_valid;
    end
    if (!ok) chk(nm, bus.out_valid, 1);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    force_redir = 0; redir_on_rsp = 0; force_pc = '0;
    fault_addr = 32'hFFFF_FFFF;
    idle_inputs();
    zero_wait();

    // 1: reset latency and steady 1/cycle stream
    do_reset();
    @(negedge clk);
    chk("t1_req_valid_c0", bus.imem_req_valid, 1);
    chk("t1_req_addr_c0", bus.imem_req_addr, 32'h0);
    step(1); @(negedge clk);
    chk("t1_out_valid_c1", bus.out_valid, 0);
    for (int k = 0; k < 3; k++) begin
      step(1); @(negedge clk);
      chk("t1_out_valid_stream", bus.out_valid, 1);
      chk("t1_out_pc_stream", bus.out_pc, 32'(4 * k));
    end
    step(20);

    // 2: decode stall fills the FIFO, release drains in order
    p_out_rdy = 0;
    do_reset();
    step(11); @(negedge clk);
    chk("t2_req_valid_full", bus.imem_req_valid, 0);
    p_out_rdy = 100;
    for (int k = 0; k < 4; k++) begin
      step(1); @(negedge clk);
      chk("t2_drain_pc", bus.out_pc, 32'(4 * k));
    end
    step(10);

    // 3: two in flight at latency 3, then redirect
    lat_min = 3; lat_max = 3;
    do_reset();
    for (int i = 0; i < 20 && mem_q.size() != 2; i++) step(1);
    force_redir = 1; force_pc = 32'h100;
    step(1); @(negedge clk);
    chk("t3_req_valid_redirect", bus.imem_req_valid, 0);
    step(1); @(negedge clk);
    chk("t3_out_valid_after_flush", bus.out_valid, 0);
    wait_out("t3_timeout");
    chk("t3_first_pc", bus.out_pc, 32'h100);
    step(10);

    // 4: misaligned redirect target
    zero_wait();
    force_redir = 1; force_pc = 32'h102;
    step(1);
    wait_out("t4_timeout");
    chk("t4_trap_valid", bus.out_trap_valid, 1);
    chk("t4_cause", bus.out_trap_cause, 32'(CAUSE_INST_MISALIGNED));
    chk("t4_tval", bus.out_trap_tval, 32'h102);
    chk("t4_inst", bus.out_inst, 32'h13);
    step(6); @(negedge clk);
    chk("t4_halt_no_req", bus.imem_req_valid, 0);

    // 5: access fault at 0x40
    fault_addr = 32'h40;
    force_redir = 1; force_pc = 32'h38;
    step(1);
    wait_out("t5_timeout");
    chk("t5_pc0", bus.out_pc, 32'h38);
    chk("t5_trap0", bus.out_trap_valid, 0);
    step(1); @(negedge clk);
    chk("t5_pc1", bus.out_pc, 32'h3C);
    step(1); @(negedge clk);
    chk("t5_trap_pc", bus.out_pc, 32'h40);
    chk("t5_trap_valid", bus.out_trap_valid, 1);
    chk("t5_cause", bus.out_trap_cause, 32'(CAUSE_INST_ACCESS_FAULT));
    chk("t5_tval", bus.out_trap_tval, 32'h40);
    step(5); @(negedge clk);
    chk("t5_halt_no_req", bus.imem_req_valid, 0);
    fault_addr = 32'hFFFF_FFFF;

    // 6: redirect on a response with a near-full FIFO, then reset mid-fetch
    lat_min = 2; lat_max = 2; p_out_rdy = 0;
    do_reset();
    for (int i = 0; i < 40 && !(exp_q.size() == DEPTH - 1 && mem_q.size() == 1); i++) step(1);
    p_out_rdy = 100; redir_on_rsp = 1; force_pc = 32'h200;
    for (int i = 0; i < 10 && redir_on_rsp; i++) step(1);
    chk("t6_redirect_with_rsp", bus.redirect_valid && bus.imem_rsp_valid, 1);
    wait_out("t6_timeout");
    chk("t6_first_pc", bus.out_pc, 32'h200);
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && mem_q.size() == 0; i++) step(1);
    do_reset();
    @(negedge clk);
    chk("t6_post_rst_out_valid", bus.out_valid, 0);
    chk("t6_post_rst_addr", bus.imem_req_addr, RPC);
    chk("t6_post_rst_req_valid", bus.imem_req_valid, 1);
    step(10);

    // random phase
    for (int seg = 0; seg < 15; seg++) begin
      p_req_rdy  = $urandom_range(100, 30);
      p_out_rdy  = $urandom_range(100, 20);
      p_rsp      = $urandom_range(100, 30);
      lat_min    = $urandom_range(2, 1);
      lat_max    = lat_min + $urandom_range(2);
      p_redir    = $urandom_range(50, 10);
      fault_addr = {22'd0, 8'($urandom_range(255)), 2'b00};
      if (seg % 5 == 4) do_reset();
      step(200);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
